// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: front-end PC generator feeding the BTB, building 2-wide fetch
// bundles from its two-slot prediction and buffering them in a fetch queue that
// drains to decode over a valid/ready handshake. Commit redirects flush and restart.
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    FQ_DEPTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   pc_valid,
  input  logic                   predict_taken_0,
  input  logic [ADDR_WIDTH-1:0]  predict_target_0,
  input  logic                   predict_taken_1,
  input  logic [ADDR_WIDTH-1:0]  predict_target_1,
  output logic [ADDR_WIDTH-1:0]  imem_addr_0,
  output logic [ADDR_WIDTH-1:0]  imem_addr_1,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_0,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_1,
  input  logic                   fetch_stall,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   deq_valid_0,
  output logic                   deq_valid_1,
  output logic [ADDR_WIDTH-1:0]  deq_pc_0,
  output logic [ADDR_WIDTH-1:0]  deq_pc_1,
  output logic [INSTR_WIDTH-1:0] deq_instr_0,
  output logic [INSTR_WIDTH-1:0] deq_instr_1,
  output logic                   deq_pred_taken_0,
  output logic                   deq_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]  deq_pred_target_0,
  output logic [ADDR_WIDTH-1:0]  deq_pred_target_1,
  input  logic                   deq_ready
);

  localparam int               IDX_W       = $clog2(FQ_DEPTH);
  localparam int               PTR_W       = IDX_W + 1;
  localparam logic [PTR_W-1:0] FETCH_LIMIT = PTR_W'(FQ_DEPTH - 2);
  localparam logic [PTR_W-1:0] ONE         = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO         = PTR_W'(2);

  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_count;

  logic [ADDR_WIDTH-1:0]  r_q_pc     [FQ_DEPTH];
  logic [INSTR_WIDTH-1:0] r_q_instr  [FQ_DEPTH];
  logic                   r_q_taken  [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_q_target [FQ_DEPTH];

  logic                   w_fetch_en;
  logic [PTR_W-1:0]       w_pop_n;
  logic [PTR_W-1:0]       w_push_n;
  logic [IDX_W-1:0]       w_wr_idx0;
  logic [IDX_W-1:0]       w_wr_idx1;
  logic [IDX_W-1:0]       w_rd_idx0;
  logic [IDX_W-1:0]       w_rd_idx1;

  // Free space is judged on the pre-pop count so the decision never depends on deq_ready.
  assign w_fetch_en = !rst && !redirect_valid && !fetch_stall && (r_count <= FETCH_LIMIT);
  assign w_push_n   = w_fetch_en ? TWO : '0;

  assign w_wr_idx0  = r_wr_ptr[IDX_W-1:0];
  assign w_wr_idx1  = w_wr_idx0 + 1'b1;
  assign w_rd_idx0  = r_rd_ptr[IDX_W-1:0];
  assign w_rd_idx1  = w_rd_idx0 + 1'b1;

  assign pc          = r_pc;
  assign pc_valid    = w_fetch_en;
  assign imem_addr_0 = r_pc;
  assign imem_addr_1 = predict_target_0;

  assign deq_valid_0       = (r_count >= ONE);
  assign deq_valid_1       = (r_count >= TWO);
  assign deq_pc_0          = r_q_pc[w_rd_idx0];
  assign deq_pc_1          = r_q_pc[w_rd_idx1];
  assign deq_instr_0       = r_q_instr[w_rd_idx0];
  assign deq_instr_1       = r_q_instr[w_rd_idx1];
  assign deq_pred_taken_0  = r_q_taken[w_rd_idx0];
  assign deq_pred_taken_1  = r_q_taken[w_rd_idx1];
  assign deq_pred_target_0 = r_q_target[w_rd_idx0];
  assign deq_pred_target_1 = r_q_target[w_rd_idx1];

  // Pop up to two entries on deq_ready; a redirect cancels the pop.
  always_comb begin
    w_pop_n = '0;
    if (!redirect_valid && deq_ready) begin
      if (r_count >= TWO) w_pop_n = TWO;
      else                w_pop_n = r_count;
    end
  end

  // Control state: PC, queue pointers and occupancy; redirect overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= redirect_pc;
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_fetch_en) r_pc <= predict_target_1;
      r_rd_ptr <= r_rd_ptr + w_pop_n;
      r_wr_ptr <= r_wr_ptr + w_push_n;
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  // Queue storage: two consecutive entries per fetch, index wraps naturally at the top.
  always_ff @(posedge clk) begin
    if (w_fetch_en) begin
      r_q_pc[w_wr_idx0]     <= r_pc;
      r_q_instr[w_wr_idx0]  <= imem_rdata_0;
      r_q_taken[w_wr_idx0]  <= predict_taken_0;
      r_q_target[w_wr_idx0] <= predict_target_0;
      r_q_pc[w_wr_idx1]     <= predict_target_0;
      r_q_instr[w_wr_idx1]  <= imem_rdata_1;
      r_q_taken[w_wr_idx1]  <= predict_taken_1;
      r_q_target[w_wr_idx1] <= predict_target_1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenario bench for fetch_pc_unit with a simple
// BTB/imem stand-in (sequential unless the taken scenario is armed).
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        predict_taken_0;
  logic [31:0] predict_target_0;
  logic        predict_taken_1;
  logic [31:0] predict_target_1;
  logic [31:0] imem_addr_0;
  logic [31:0] imem_addr_1;
  logic [31:0] imem_rdata_0;
  logic [31:0] imem_rdata_1;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid_0;
  logic        deq_valid_1;
  logic [31:0] deq_pc_0;
  logic [31:0] deq_pc_1;
  logic [31:0] deq_instr_0;
  logic [31:0] deq_instr_1;
  logic        deq_pred_taken_0;
  logic        deq_pred_taken_1;
  logic [31:0] deq_pred_target_0;
  logic [31:0] deq_pred_target_1;
  logic        deq_ready;

  logic        bt_tk;
  int          n_chk;
  int          n_pass;

  fetch_pc_unit #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .FQ_DEPTH(8), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid),
    .predict_taken_0(predict_taken_0), .predict_target_0(predict_target_0),
    .predict_taken_1(predict_taken_1), .predict_target_1(predict_target_1),
    .imem_addr_0(imem_addr_0), .imem_addr_1(imem_addr_1),
    .imem_rdata_0(imem_rdata_0), .imem_rdata_1(imem_rdata_1),
    .fetch_stall(fetch_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .deq_valid_0(deq_valid_0), .deq_valid_1(deq_valid_1),
    .deq_pc_0(deq_pc_0), .deq_pc_1(deq_pc_1),
    .deq_instr_0(deq_instr_0), .deq_instr_1(deq_instr_1),
    .deq_pred_taken_0(deq_pred_taken_0), .deq_pred_taken_1(deq_pred_taken_1),
    .deq_pred_target_0(deq_pred_target_0), .deq_pred_target_1(deq_pred_target_1),
    .deq_ready(deq_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BTB and instruction memory stand-in: fall-through unless slot 0 at 0x10 is armed taken.
  always_comb begin
    predict_taken_0  = bt_tk && (pc == 32'h10);
    predict_target_0 = predict_taken_0 ? 32'h80 : pc + 32'd4;
    predict_taken_1  = 1'b0;
    predict_target_1 = predict_target_0 + 32'd4;
    imem_rdata_0     = ~imem_addr_0;
    imem_rdata_1     = ~imem_addr_1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    deq_ready = 1'b1; bt_tk = 1'b0;
    step(); step();
    n_chk++; if (pc !== 32'h0) $display("FAIL rst_pc got %h exp %h", pc, 32'h0); else n_pass++;
    n_chk++; if (pc_valid !== 1'b0) $display("FAIL rst_pc_valid got %b exp 0", pc_valid); else n_pass++;
    n_chk++; if (deq_valid_0 !== 1'b0) $display("FAIL rst_deq_valid_0 got %b exp 0", deq_valid_0); else n_pass++;
    n_chk++; if (deq_valid_1 !== 1'b0) $display("FAIL rst_deq_valid_1 got %b exp 0", deq_valid_1); else n_pass++;
  endtask

  task automatic test_sequential();
    rst = 1'b0;
    #1;
    n_chk++; if (pc_valid !== 1'b1) $display("FAIL seq_first_valid got %b exp 1", pc_valid); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++; if (deq_valid_0 !== 1'b1 || deq_valid_1 !== 1'b1)
        $display("FAIL seq_valid[%0d] got %b%b exp 11", k, deq_valid_0, deq_valid_1); else n_pass++;
      n_chk++; if (deq_pc_0 !== 32'(8*k)) $display("FAIL seq_pc0[%0d] got %h exp %h", k, deq_pc_0, 32'(8*k)); else n_pass++;
      n_chk++; if (deq_pc_1 !== 32'(8*k+4)) $display("FAIL seq_pc1[%0d] got %h exp %h", k, deq_pc_1, 32'(8*k+4)); else n_pass++;
      n_chk++; if (deq_instr_0 !== ~32'(8*k)) $display("FAIL seq_instr0[%0d] got %h exp %h", k, deq_instr_0, ~32'(8*k)); else n_pass++;
      n_chk++; if (deq_instr_1 !== ~32'(8*k+4)) $display("FAIL seq_instr1[%0d] got %h exp %h", k, deq_instr_1, ~32'(8*k+4)); else n_pass++;
    end
    n_chk++; if (pc !== 32'h10) $display("FAIL seq_next_pc got %h exp %h", pc, 32'h10); else n_pass++;
  endtask

  task automatic test_taken();
    bt_tk = 1'b1;
    step();
    bt_tk = 1'b0;
    n_chk++; if (deq_pc_0 !== 32'h10) $display("FAIL tk_pc0 got %h exp %h", deq_pc_0, 32'h10); else n_pass++;
    n_chk++; if (deq_pred_taken_0 !== 1'b1) $display("FAIL tk_taken0 got %b exp 1", deq_pred_taken_0); else n_pass++;
    n_chk++; if (deq_pred_target_0 !== 32'h80) $display("FAIL tk_tgt0 got %h exp %h", deq_pred_target_0, 32'h80); else n_pass++;
    n_chk++; if (deq_pc_1 !== 32'h80) $display("FAIL tk_pc1 got %h exp %h", deq_pc_1, 32'h80); else n_pass++;
    n_chk++; if (deq_pred_taken_1 !== 1'b0) $display("FAIL tk_taken1 got %b exp 0", deq_pred_taken_1); else n_pass++;
    n_chk++; if (deq_pred_target_1 !== 32'h84) $display("FAIL tk_tgt1 got %h exp %h", deq_pred_target_1, 32'h84); else n_pass++;
    n_chk++; if (deq_instr_1 !== ~32'h80) $display("FAIL tk_instr1 got %h exp %h", deq_instr_1, ~32'h80); else n_pass++;
    n_chk++; if (pc !== 32'h84) $display("FAIL tk_next_pc got %h exp %h", pc, 32'h84); else n_pass++;
  endtask

  task automatic test_backpressure();
    fetch_stall = 1'b1; deq_ready = 1'b1;
    step();
    n_chk++; if (deq_valid_0 !== 1'b0) $display("FAIL bp_drained got %b exp 0", deq_valid_0); else n_pass++;
    fetch_stall = 1'b0; deq_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_chk++; if (pc !== 32'(32'h84 + 8*((i > 4) ? 4 : i)))
        $display("FAIL bp_pc[%0d] got %h exp %h", i, pc, 32'(32'h84 + 8*((i > 4) ? 4 : i))); else n_pass++;
      n_chk++; if (pc_valid !== (i < 4)) $display("FAIL bp_pc_valid[%0d] got %b exp %b", i, pc_valid, (i < 4)); else n_pass++;
    end
    n_chk++; if (deq_pc_0 !== 32'h84 || deq_pc_1 !== 32'h88)
      $display("FAIL bp_head_stable got %h/%h exp 84/88", deq_pc_0, deq_pc_1); else n_pass++;
    deq_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_chk++; if (deq_pc_0 !== 32'(32'h84 + 8*k) || deq_pc_1 !== 32'(32'h88 + 8*k))
        $display("FAIL bp_order[%0d] got %h/%h exp %h/%h", k, deq_pc_0, deq_pc_1,
                 32'(32'h84 + 8*k), 32'(32'h88 + 8*k)); else n_pass++;
    end
    n_chk++; if (pc !== 32'hBC) $display("FAIL bp_resume_pc got %h exp %h", pc, 32'hBC); else n_pass++;
  endtask

  task automatic test_redirect_full();
    deq_ready = 1'b0;
    step();
    n_chk++; if (pc !== 32'hC4 || pc_valid !== 1'b0)
      $display("FAIL rd_full got pc %h valid %b exp C4/0", pc, pc_valid); else n_pass++;
    fetch_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
    n_chk++; if (pc !== 32'h200) $display("FAIL rd_pc got %h exp %h", pc, 32'h200); else n_pass++;
    n_chk++; if (deq_valid_0 !== 1'b0 || deq_valid_1 !== 1'b0)
      $display("FAIL rd_flush got %b%b exp 00", deq_valid_0, deq_valid_1); else n_pass++;
    n_chk++; if (pc_valid !== 1'b0) $display("FAIL rd_stall_hold got %b exp 0", pc_valid); else n_pass++;
    step();
    n_chk++; if (pc !== 32'h200 || deq_valid_0 !== 1'b0)
      $display("FAIL rd_held got pc %h valid %b exp 200/0", pc, deq_valid_0); else n_pass++;
    fetch_stall = 1'b0;
    #1;
    n_chk++; if (pc_valid !== 1'b1) $display("FAIL rd_resume_valid got %b exp 1", pc_valid); else n_pass++;
    step();
    n_chk++; if (deq_pc_0 !== 32'h200 || deq_pc_1 !== 32'h204 || pc !== 32'h208)
      $display("FAIL rd_resume got %h/%h pc %h exp 200/204/208", deq_pc_0, deq_pc_1, pc); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_f;
    logic [31:0] exp_d;
    int          bundles;
    int          cyc;
    int          deqs;
    redirect_valid = 1'b1; redirect_pc = 32'h1000; deq_ready = 1'b0;
    step();
    redirect_valid = 1'b0;
    exp_f = 32'h1000; exp_d = 32'h1000; bundles = 0; cyc = 0; deqs = 0;
    while (bundles < 20 && cyc < 200) begin
      deq_ready = ((cyc % 2) == 0);
      #1;
      if (pc_valid) begin
        n_chk++; if (pc !== exp_f) $display("FAIL wrap_fetch_pc got %h exp %h", pc, exp_f); else n_pass++;
        exp_f = exp_f + 32'd8;
        bundles++;
      end
      if (deq_ready && deq_valid_0) begin
        n_chk++; if (deq_pc_0 !== exp_d || deq_pc_1 !== exp_d + 32'd4 || deq_valid_1 !== 1'b1)
          $display("FAIL wrap_deq got %h/%h v%b exp %h/%h", deq_pc_0, deq_pc_1, deq_valid_1, exp_d, exp_d + 32'd4);
        else n_pass++;
        exp_d = exp_d + 32'd8;
        deqs++;
      end
      step();
      cyc++;
    end
    n_chk++; if (bundles < 20) $display("FAIL wrap_timeout got %0d bundles exp 20", bundles); else n_pass++;
    n_chk++; if (deqs < 9) $display("FAIL wrap_deq_count got %0d exp >= 9", deqs); else n_pass++;
    deq_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3000;
    #1;
    n_chk++; if (pc_valid !== 1'b0) $display("FAIL wrap_rd_pc_valid got %b exp 0", pc_valid); else n_pass++;
    step();
    redirect_valid = 1'b0;
    n_chk++; if (deq_valid_0 !== 1'b0 || pc !== 32'h3000)
      $display("FAIL wrap_rd got valid %b pc %h exp 0/3000", deq_valid_0, pc); else n_pass++;
    step();
    n_chk++; if (deq_pc_0 !== 32'h3000 || deq_pc_1 !== 32'h3004)
      $display("FAIL wrap_rd_resume got %h/%h exp 3000/3004", deq_pc_0, deq_pc_1); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    deq_ready = 1'b0;
    step(); step();
    n_chk++; if (pc !== 32'h3018 || deq_valid_1 !== 1'b1)
      $display("FAIL mr_fill got pc %h v1 %b exp 3018/1", pc, deq_valid_1); else n_pass++;
    rst = 1'b1;
    step();
    n_chk++; if (deq_valid_0 !== 1'b0 || pc !== 32'h0 || pc_valid !== 1'b0)
      $display("FAIL mr_reset got v0 %b pc %h pv %b exp 0/0/0", deq_valid_0, pc, pc_valid); else n_pass++;
    rst = 1'b0; deq_ready = 1'b1;
    step();
    n_chk++; if (deq_pc_0 !== 32'h0 || deq_pc_1 !== 32'h4 || deq_valid_1 !== 1'b1)
      $display("FAIL mr_first got %h/%h v%b exp 0/4/1", deq_pc_0, deq_pc_1, deq_valid_1); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_sequential();
    test_taken();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
